alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports: req0_aluop / req1_aluop  input  2  ALUOp class of the request.
REQ-007 SHALL have ports: req0_funct / req1_funct  input  4  Funct field of the request.
REQ-008 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-009 SHALL have ports: alu_op  output  4  Operation code to shared ALU; alu_a, alu_b  output  WIDTH  operands to shared ALU.
REQ-010 SHALL have ports: alu_result  input  WIDTH  and alu_zero  input  1  combinational ALU outputs.
REQ-011 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_id  output  1  requester served; resp_result  output  WIDTH; resp_zero  output  1; resp_err  output  1  illegal encoding.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 SHALL, in IDLE with any reqN_valid, grant exactly one requester and assert its reqN_ready in that same cycle (combinational from state and valids); transition to EXEC.
REQ-014 SHALL arbitrate round-robin: single valid -> granted; both valid -> the requester not granted last; last-grant pointer resets to 1 (so requester 0 wins first tie).
REQ-015 SHALL latch granted operands, decoded op, error flag and id on the accept edge; requester inputs are don't-care afterwards.
REQ-016 SHALL decode op: ALUOp 00 -> 0010; 01 -> 0110; 10 with Funct 0000 -> 0010, 1000 -> 0110, 0111 -> 0000, 0110 -> 0001.
REQ-017 SHALL flag illegal: ALUOp 11, or ALUOp 10 with any other Funct -> err=1, op latched as 0010.
REQ-018 SHALL drive alu_op/alu_a/alu_b from latched registers in all states (stable, no glitch on grant); in EXEC capture alu_result/alu_zero into response registers; transition to RESP.
REQ-019 SHALL, on err=1, capture resp_result=0 and resp_zero=0 regardless of ALU inputs.
REQ-020 SHALL assert resp_valid only in RESP, with resp_id/result/zero/err stable until resp_valid&&resp_ready.
REQ-021 SHALL return to IDLE on the handshake edge; no new request accepted in EXEC or RESP (reqN_ready=0).
REQ-022 SHALL give latency: accept in cycle T, resp_valid first high in T+2; max throughput one operation per 3 cycles.
REQ-023 SHALL not drop a request: a valid deasserted before ready is simply not served; valid held across busy cycles is served once IDLE is reached.
REQ-024 SHALL tolerate resp_ready held high continuously (back-to-back operations every 3 cycles, alternating if both valid).

Reset
REQ-025 SHALL, on reset high at any clock edge (including mid-EXEC/RESP), go to IDLE, clear resp_valid, resp_id, resp_result, resp_zero, resp_err, alu_op, alu_a, alu_b to 0, set last-grant to 1; in-flight operation discarded.
REQ-026 SHALL hold req0_ready=req1_ready=0 while reset is high.

Verification
REQ-027 SHALL cover: req0 ALUOp=10 Funct=0000 a=5 b=7 -> req0_ready at T, alu_op=0010 at T+1, resp at T+2: id=0 result=12 zero=0 err=0.
REQ-028 SHALL cover: both valid continuously, resp_ready=1 -> grants 0,1,0,1 with accepts 3 cycles apart.
REQ-029 SHALL cover: req1 ALUOp=01 a=9 b=9 -> alu_op=0110, resp_result=0, resp_zero=1, id=1.
REQ-030 SHALL cover: req0 ALUOp=11 and separately ALUOp=10 Funct=0101 -> resp_err=1, resp_result=0.
REQ-031 SHALL cover: resp_ready=0 for 5 cycles in RESP -> resp_valid and fields stable, both readys 0; release -> IDLE next cycle.
REQ-032 SHALL cover: reset asserted in EXEC -> next cycle resp_valid=0, all outputs 0, next tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. A
//   round-robin arbiter accepts one request at a time in IDLE. The ALU
//   control decode turns ALUOp/Funct into a 4-bit ALU operation. The ALU
//   result is captured one cycle after accept and presented through a
//   valid/ready response port.
//
// Ports:
//   clk                     clock, rising edge
//   reset                   synchronous active-high reset
//   req0_valid/req1_valid   requester has an operation pending
//   req0_ready/req1_ready   request accepted this cycle
//   req0_aluop/req1_aluop   2-bit ALUOp class
//   req0_funct/req1_funct   4-bit Funct field
//   req0_a/b, req1_a/b      operands
//   alu_op, alu_a, alu_b    operation and operands driven to the shared ALU
//   alu_result, alu_zero    combinational ALU outputs
//   resp_valid/resp_ready   response handshake
//   resp_id                 requester served (0/1)
//   resp_result, resp_zero  captured ALU outputs (zeroed on error)
//   resp_err                request used an illegal ALUOp/Funct encoding
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [1:0]       req0_aluop,
  input  logic [1:0]       req1_aluop,
  input  logic [3:0]       req0_funct,
  input  logic [3:0]       req1_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastGrant;
  logic [3:0]       r_aluOp;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic             r_err;
  logic             r_id;
  logic [WIDTH-1:0] r_respResult;
  logic             r_respZero;

  logic             w_grantValid;
  logic             w_grantId;
  logic             w_accept;
  logic [1:0]       w_selAluop;
  logic [3:0]       w_selFunct;
  logic [3:0]       w_decOp;
  logic             w_decErr;

  // Round-robin grant. On a tie the requester that did not win last time is
  // chosen; a lone valid is always granted. The accept is qualified with
  // reset so neither ready can rise while reset is held.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantId    = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grantValid = 1'b1;
      w_grantId    = ~r_lastGrant;
    end else if (req0_valid) begin
      w_grantValid = 1'b1;
      w_grantId    = 1'b0;
    end else if (req1_valid) begin
      w_grantValid = 1'b1;
      w_grantId    = 1'b1;
    end
  end

  assign w_accept   = (r_state == IDLE) && !reset && w_grantValid;
  assign req0_ready = w_accept && !w_grantId;
  assign req1_ready = w_accept && w_grantId;

  // ALU control decode of the granted request. Illegal encodings still
  // produce a harmless add so the ALU inputs stay well defined.
  always_comb begin
    w_selAluop = w_grantId ? req1_aluop : req0_aluop;
    w_selFunct = w_grantId ? req1_funct : req0_funct;
    w_decOp    = 4'b0010;
    w_decErr   = 1'b0;
    case (w_selAluop)
      2'b00: w_decOp = 4'b0010;
      2'b01: w_decOp = 4'b0110;
      2'b10: begin
        case (w_selFunct)
          4'b0000: w_decOp = 4'b0010;
          4'b1000: w_decOp = 4'b0110;
          4'b0111: w_decOp = 4'b0000;
          4'b0110: w_decOp = 4'b0001;
          default: w_decErr = 1'b1;
        endcase
      end
      default: w_decErr = 1'b1;
    endcase
  end

  // Next-state logic: accept, one execute cycle, then hold the response
  // until the consumer takes it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grantValid) w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    if (resp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State and datapath registers. The ALU drive comes straight from these
  // registers, so the shared ALU never sees requester inputs switching
  // during a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lastGrant  <= 1'b1;
      r_aluOp      <= 4'b0000;
      r_aluA       <= '0;
      r_aluB       <= '0;
      r_err        <= 1'b0;
      r_id         <= 1'b0;
      r_respResult <= '0;
      r_respZero   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_lastGrant <= w_grantId;
        r_id        <= w_grantId;
        r_aluOp     <= w_decOp;
        r_err       <= w_decErr;
        r_aluA      <= w_grantId ? req1_a : req0_a;
        r_aluB      <= w_grantId ? req1_b : req0_b;
      end
      if (r_state == EXEC) begin
        r_respResult <= r_err ? '0 : alu_result;
        r_respZero   <= r_err ? 1'b0 : alu_zero;
      end
    end
  end

  assign alu_op      = r_aluOp;
  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign resp_valid  = (r_state == RESP);
  assign resp_id     = r_id;
  assign resp_result = r_respResult;
  assign resp_zero   = r_respZero;
  assign resp_err    = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Drives alu_arbiter with directed scenarios followed by random traffic.
//   It models the shared ALU and keeps a transaction-level reference: a busy
//   flag, the age of the in-flight operation, the last winner, and the
//   arithmetic result each request should produce.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_aluop, req1_aluop;
  logic [3:0]   req0_funct, req1_funct;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;
  logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [W-1:0] resp_result;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  bit           mBusy = 1'b0;
  int           mAge = 0;
  bit           mLast = 1'b1;
  bit           mJustReset = 1'b0;
  bit           mId, mErr, mZero;
  logic [3:0]   mOp;
  logic [W-1:0] mA, mB, mResult;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_aluop(req0_aluop), .req1_aluop(req1_aluop),
    .req0_funct(req0_funct), .req1_funct(req1_funct),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // The shared combinational ALU the arbiter drives.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nChecks++;
    assert (obs === exp) begin
      nPass++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // -1 means nobody is granted.
  function automatic int pickGrant(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // What a request means arithmetically, independent of how it is encoded.
  task automatic refCompute(input logic [1:0] aluop, input logic [3:0] funct,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    mErr = 1'b0;
    mOp = 4'b0010;
    mResult = a + b;
    if (aluop == 2'b01) begin
      mOp = 4'b0110; mResult = a - b;
    end else if (aluop == 2'b10) begin
      if (funct == 4'b1000) begin mOp = 4'b0110; mResult = a - b; end
      else if (funct == 4'b0111) begin mOp = 4'b0000; mResult = a & b; end
      else if (funct == 4'b0110) begin mOp = 4'b0001; mResult = a | b; end
      else if (funct != 4'b0000) mErr = 1'b1;
    end else if (aluop == 2'b11) begin
      mErr = 1'b1;
    end
    if (mErr) begin
      mResult = '0; mZero = 1'b0;
    end else begin
      mZero = (mResult == '0);
    end
  endtask

  task automatic checkOutput();
    int g;
    g = pickGrant(req0_valid, req1_valid, mLast);
    check("req0_ready", req0_ready, !reset && !mBusy && g == 0);
    check("req1_ready", req1_ready, !reset && !mBusy && g == 1);
    check("resp_valid", resp_valid, mBusy && mAge == 2);
    if (mBusy) begin
      check("alu_op", alu_op, mOp);
      check("alu_a", alu_a, mA);
      check("alu_b", alu_b, mB);
    end
    if (mBusy && mAge == 2) begin
      check("resp_id", resp_id, mId);
      check("resp_result", resp_result, mResult);
      check("resp_zero", resp_zero, mZero);
      check("resp_err", resp_err, mErr);
    end
    if (mJustReset && !mBusy) begin
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_result", resp_result, 0);
      check("rst_resp_zero", resp_zero, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
    end
  endtask

  // Advance the reference model across one rising edge.
  task automatic updateModel();
    int g;
    if (reset) begin
      mBusy = 1'b0; mLast = 1'b1; mJustReset = 1'b1;
    end else if (mBusy) begin
      if (mAge == 2) begin
        if (resp_ready) mBusy = 1'b0;
      end else begin
        mAge = 2;
      end
    end else begin
      g = pickGrant(req0_valid, req1_valid, mLast);
      if (g >= 0) begin
        mId = (g == 1);
        mA  = mId ? req1_a : req0_a;
        mB  = mId ? req1_b : req0_b;
        refCompute(mId ? req1_aluop : req0_aluop, mId ? req1_funct : req0_funct, mA, mB);
        mBusy = 1'b1; mAge = 1; mLast = mId; mJustReset = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check just after, then
  // step the model across the rising edge.
  task automatic applyStimulus(input bit rst, input bit v0, input bit v1,
                               input logic [1:0] ao0, input logic [3:0] f0,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [1:0] ao1, input logic [3:0] f1,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input bit rr);
    reset = rst; req0_valid = v0; req1_valid = v1;
    req0_aluop = ao0; req0_funct = f0; req0_a = a0; req0_b = b0;
    req1_aluop = ao1; req1_funct = f1; req1_a = a1; req1_b = b1;
    resp_ready = rr;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input bit rr);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0, rr);
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [3:0] pickFunct();
    case ($urandom_range(0, 4))
      0: return 4'b0000;
      1: return 4'b1000;
      2: return 4'b0111;
      3: return 4'b0110;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;
    reset = 1'b1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_aluop = 0; req1_aluop = 0; req0_funct = 0; req1_funct = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(1, 1, 1, 2'b00, 4'h0, 1, 2, 2'b00, 4'h0, 3, 4, 1);
    applyStimulus(1, 1, 0, 2'b00, 4'h0, 1, 2, 2'b00, 4'h0, 3, 4, 1);

    $display("[TB] single add on requester 0");
    applyStimulus(0, 1, 0, 2'b10, 4'b0000, 5, 7, 2'b00, 4'h0, 0, 0, 1);
    idleCycles(3, 1);
    check("add_5_7_expected", mResult, 64'd12);

    $display("[TB] both requesters continuously valid");
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 1, 2'b00, 4'h0, 64'(10 + i), 3, 2'b01, 4'h0, 64'(40 + i), 1, 1);
    idleCycles(2, 1);

    $display("[TB] subtract to zero on requester 1");
    applyStimulus(0, 0, 1, 2'b00, 4'h0, 0, 0, 2'b01, 4'h0, 9, 9, 1);
    idleCycles(3, 1);

    $display("[TB] illegal encodings");
    applyStimulus(0, 1, 0, 2'b11, 4'h0, 33, 44, 2'b00, 4'h0, 0, 0, 1);
    idleCycles(3, 1);
    applyStimulus(0, 1, 0, 2'b10, 4'b0101, 33, 44, 2'b00, 4'h0, 0, 0, 1);
    idleCycles(3, 1);

    $display("[TB] response back-pressure");
    applyStimulus(0, 1, 0, 2'b10, 4'b0110, 64'hF0, 64'h0F, 2'b00, 4'h0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 1, 2'b10, 4'b0111, 1, 1, 2'b00, 4'h0, 2, 2, 0);
    applyStimulus(0, 1, 1, 2'b10, 4'b0111, 1, 1, 2'b00, 4'h0, 2, 2, 1);
    applyStimulus(0, 0, 1, 2'b00, 4'h0, 0, 0, 2'b00, 4'h0, 2, 2, 1);
    idleCycles(4, 1);

    $display("[TB] reset during execute");
    applyStimulus(0, 1, 0, 2'b00, 4'h0, 8, 8, 2'b00, 4'h0, 0, 0, 1);
    applyStimulus(1, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0, 1);
    applyStimulus(0, 1, 1, 2'b00, 4'h0, 100, 1, 2'b00, 4'h0, 200, 1, 1);
    idleCycles(3, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      ra0 = rnd64(); rb0 = ($urandom_range(0, 3) == 0) ? ra0 : rnd64();
      ra1 = rnd64(); rb1 = ($urandom_range(0, 3) == 0) ? ra1 : rnd64();
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    2'($urandom_range(0, 3)), pickFunct(), ra0, rb0,
                    2'($urandom_range(0, 3)), pickFunct(), ra1, rb1,
                    $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
